// File: rtl/core_sequencer.sv
// core_sequencer
// ----------------------------------------------------------------------------
// Multicycle control sequencer for the RV32 core. Drives the 3-bit stage
// state seen by decode and the other stage blocks, handshakes instruction and
// data memory, skips MEM for non-memory instructions, owns the program
// counter and branch/jump target selection, counts retired instructions and
// stops cleanly at an instruction boundary on request.
//
// Ports
//   clk             in   core clock, all state changes on posedge
//   rst             in   asynchronous active-high reset
//   state           out  FETCH=0 DECODE=1 EXEC=2 MEM=3 WRITE=4 HALT=7
//   pc              out  address of the current instruction
//   imem_req        out  instruction fetch request (FETCH, not in reset)
//   imem_ready      in   fetch data valid (only looked at in FETCH)
//   dmem_req        out  data access request (MEM)
//   dmem_ready      in   data access complete (only looked at in MEM)
//   mem_read        in   decoded load control, valid from EXEC onward
//   mem_write       in   decoded store control, valid from EXEC onward
//   reg_write       in   decoded register write control
//   branch_c        in   conditional branch
//   branch_uc       in   unconditional jump
//   branch_relative in   jump is pc-relative (jal) rather than register (jalr)
//   cmp_true        in   ALU comparison result, valid in EXEC
//   imm             in   decoded immediate
//   alu_result      in   ALU output, valid in EXEC
//   rf_we           out  register-file write enable (WRITE & reg_write)
//   retire          out  one-cycle pulse per completed instruction
//   instret         out  retired-instruction count (wraps)
//   halt_req        in   stop after the current instruction (sticky)
//   halted          out  high while in HALT
// ----------------------------------------------------------------------------
module core_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [2:0]  state,
    output logic [31:0] pc,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        branch_c,
    input  logic        branch_uc,
    input  logic        branch_relative,
    input  logic        cmp_true,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    output logic        rf_we,
    output logic        retire,
    output logic [31:0] instret,
    input  logic        halt_req,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WRITE  = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instret;
    logic [31:0] r_target_q;
    logic        r_halt_pend;
    logic [31:0] w_target;
    logic [31:0] w_pc_rel;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH:  if (imem_ready) w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = S_EXEC;
            S_EXEC:   w_state_nxt = (mem_read | mem_write) ? S_MEM : S_WRITE;
            S_MEM:    if (dmem_ready) w_state_nxt = S_WRITE;
            // halt_req is OR-ed in directly so a request seen in WRITE
            // itself still stops at this boundary.
            S_WRITE:  w_state_nxt = (r_halt_pend | halt_req) ? S_HALT : S_FETCH;
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_FETCH;
        endcase
    end

    // ------------------------------------------------------- target select
    // Priority: jalr, jal, taken conditional branch, fall-through.
    // jalr clears bit 0 of the computed address.
    always_comb begin
        w_pc_rel = r_pc + imm;
        w_target = r_pc + 32'd4;
        if (branch_uc && !branch_relative) begin
            w_target = alu_result & 32'hFFFF_FFFE;
        end else if (branch_uc && branch_relative) begin
            w_target = w_pc_rel;
        end else if (branch_c && cmp_true) begin
            w_target = w_pc_rel;
        end
    end

    // ------------------------------------------------------------ datapath
    // The target is captured at the end of EXEC so later changes on
    // alu_result/imm cannot disturb the pc update in WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_instret   <= 32'd0;
            r_target_q  <= 32'd0;
            r_halt_pend <= 1'b0;
        end else begin
            if (r_state == S_EXEC) begin
                r_target_q <= w_target;
            end
            if (r_state == S_WRITE) begin
                r_pc      <= r_target_q;
                r_instret <= r_instret + 32'd1;
            end
            if ((r_state != S_HALT) && halt_req) begin
                r_halt_pend <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- outputs
    // Reset forces r_state to FETCH asynchronously, so every state-decoded
    // output is already 0 during reset except imem_req, which is masked.
    assign state    = r_state;
    assign pc       = r_pc;
    assign instret  = r_instret;
    assign imem_req = (r_state == S_FETCH) & ~rst;
    assign dmem_req = (r_state == S_MEM);
    assign rf_we    = (r_state == S_WRITE) & reg_write;
    assign retire   = (r_state == S_WRITE);
    assign halted   = (r_state == S_HALT);

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multicycle control sequencer for the RV32 core. It generates the 3-bit `state` consumed by the decode stage and the other stage blocks. It handshakes instruction and data memory, skips MEM for non-memory instructions, and owns the program counter and branch/jump target selection. It also counts retired instructions and supports a clean halt at an instruction boundary.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

- `clk` in 1: core clock; all state changes on posedge.
- `rst` in 1: reset, asynchronous and active-high.
- `state` out 3: FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4, HALT=7.
- `pc` out 32: address of the current instruction.
- `imem_req` out 1: instruction fetch request.
- `imem_ready` in 1: fetch data valid.
- `dmem_req` out 1: data access request.
- `dmem_ready` in 1: data access complete.
- `mem_read`, `mem_write`, `reg_write` in 1 each: decoded controls, valid from EXEC onward.
- `branch_c`, `branch_uc`, `branch_relative` in 1 each: decoded branch controls.
- `cmp_true` in 1: ALU comparison result (lt/ge), valid in EXEC.
- `imm` in 32: decoded immediate.
- `alu_result` in 32: ALU output, valid in EXEC.
- `rf_we` out 1: register-file write enable.
- `retire` out 1: one-cycle pulse per completed instruction.
- `instret` out 32: retired-instruction count.
- `halt_req` in 1: request to stop after the current instruction.
- `halted` out 1: high while `state`==HALT.

## Operation
- Reset values: `state`=FETCH, `pc`=RESET_PC, `instret`=0, internal `target_q`=0, `halt_pend`=0.
- Combinational outputs:
  - `imem_req` = (state==FETCH) & ~rst.
  - `dmem_req` = (state==MEM).
  - `rf_we` = (state==WRITE) & `reg_write`.
  - `retire` = (state==WRITE).
  - `halted` = (state==HALT).
  - During reset, all five read 0 except `dmem_req`=0 and `imem_req`=0.
- State transitions:
  - FETCH: go to DECODE when `imem_ready`=1 at posedge; otherwise stay.
  - DECODE: go to EXEC unconditionally (decode registers its outputs on this edge).
  - EXEC: go to MEM if `mem_read`|`mem_write`, else to WRITE. Latch `target_q` on this edge.
  - MEM: go to WRITE when `dmem_ready`=1; otherwise stay with `dmem_req` held.
  - WRITE: `pc`<=`target_q`; `instret`<=`instret`+1. Next state is HALT if `halt_pend`|`halt_req`, else FETCH.
  - HALT: absorbing; exits only via `rst`. `pc` and `instret` are frozen.
- Target computed in EXEC, in priority order:
  - `branch_uc` & ~`branch_relative` (jalr): `alu_result` & 32'hFFFF_FFFE.
  - `branch_uc` & `branch_relative` (jal): `pc`+`imm`.
  - `branch_c` & `cmp_true`: `pc`+`imm`.
  - Otherwise: `pc`+4.
- Arithmetic: all sums are modulo 2^32 (wrap, no trap). `instret` wraps from 32'hFFFF_FFFF to 0.
- Memory handshake rules:
  - `imem_ready` is ignored outside FETCH; `dmem_ready` is ignored outside MEM.
  - Ready may arrive in the first request cycle (zero wait) or after any number of wait cycles.
- Halt handling:
  - `halt_req` is sticky: sampled high in any non-HALT state, it sets `halt_pend`.
  - The current instruction always completes (WRITE executes, `retire` pulses) before HALT.
  - `halt_req` seen in WRITE itself takes effect on that edge.
- Reset mid-operation forces FETCH/RESET_PC immediately, regardless of any outstanding memory request. No partial write occurs after reset asserts, because `rf_we` is gated by state.

## Timing
- Minimum instruction latency: 4 cycles for non-memory instructions (FETCH, DECODE, EXEC, WRITE), 5 cycles for load/store; each wait cycle adds 1.
- `target_q` reflects EXEC-cycle inputs; later changes to `alu_result`/`imm` do not affect `pc`.
- The new `pc` is visible in the FETCH cycle immediately after WRITE.
- `instret` increments on the WRITE→FETCH/HALT edge and is visible in the following cycle.
- `rf_we` and `retire` are asserted for exactly one cycle per instruction.

## Test plan
- Reset, RESET_PC=32'h100, addi with `imem_ready` tied high → states 0,1,2,4,0; `pc` 0x100→0x104; `instret`=1; `rf_we` high for one cycle.
- Load with `dmem_ready` delayed 3 cycles → MEM held 4 cycles with `dmem_req`=1, then WRITE; total 8 cycles; `pc`+=4.
- blt with `cmp_true`=1, `imm`=-8, `pc`=0x20 → `pc`=0x18. Same instruction with `cmp_true`=0 → `pc`=0x24.
- jalr with `alu_result`=0x3F → `pc`=0x3E. jal at `pc`=0xFFFF_FFFC with `imm`=8 → `pc`=0x4 (wrap).
- `halt_req` pulsed for one cycle during DECODE → instruction completes, `retire` pulses once, then `state`=7 indefinitely with `pc` and `instret` frozen.
- `rst` asserted mid-MEM while `dmem_req` is high → same cycle `state`=0, `dmem_req`=0, `pc`=RESET_PC, `instret`=0; no `rf_we` pulse.
